uart_rx_axis: RTL
=================

// Module: uart_rx_axis
// PURPOSE
//   8N1 UART receiver, the receive-side counterpart of the 8N1 AXI-Stream UART transmitter.
//   Oversamples rx_bit with the system clock and samples each bit at mid-bit.
//   Delivers each valid byte on an AXI-Stream master holding register.
//   Flags framing errors and overruns as single-cycle pulses.
// PARAMETERS
//   CLOCK_FREQ_HZ  0  system clock frequency; must be set (>0)
//   BAUD_RATE      0  line rate; must be set, CLOCK_FREQ_HZ/BAUD_RATE >= 4
// PORTS
//   m_axis_aclk     in   1  sole clock
//   m_axis_areset   in   1  synchronous reset, active-high
//   rx_bit          in   1  asynchronous UART line, idle high
//   m_axis_tvalid   out  1  received byte available
//   m_axis_tdata    out  8  received byte, bit 0 = first data bit on line
//   m_axis_tready   in   1  downstream accepts byte
//   framing_error   out  1  1-cycle pulse: stop bit sampled low
//   overrun         out  1  1-cycle pulse: byte completed while tvalid still high
// BEHAVIOUR
//   - Constants: UART_CYCLES = CLOCK_FREQ_HZ/BAUD_RATE (integer divide); HALF = UART_CYCLES/2.
//     Counter width = $clog2(UART_CYCLES).
//   - rx_bit passes through a 2-flop synchronizer (both flops reset to 1) -> rx_s.
//     All FSM decisions use rx_s only.
//   - Reset values:
//     - state=IDLE, counter=0
//     - m_axis_tvalid=0, m_axis_tdata=8'h00
//     - framing_error=0, overrun=0
//   - Reset mid-frame aborts the frame; no tvalid and no error pulse for that frame.
//   - States:
//     - IDLE:  rx_s==0 -> START, cnt<=0.
//     - START: cnt==HALF-1: rx_s==0 -> DATA (idx<=0, cnt<=0); rx_s==1 -> IDLE (glitch, no flags).
//     - DATA:  cnt==UART_CYCLES-1: shift_reg <= {rx_s, shift_reg[7:1]}, cnt<=0, idx++.
//              After the sample with idx==7 -> STOP.
//     - STOP:  cnt==UART_CYCLES-1: sample rx_s, then -> IDLE.
//              rx_s==1 -> deliver byte. rx_s==0 -> framing_error pulse, byte discarded.
//     - In all non-IDLE states, cnt increments when not at its terminal value.
//   - Next start bit is detectable from the cycle after STOP exits (mid stop bit).
//     Back-to-back frames must work.
//   - Deliver byte:
//     - if tvalid==0 or (tvalid && tready) same cycle: tdata<=shift_reg, tvalid<=1.
//     - else (tvalid && !tready): keep old tdata, drop new byte, overrun pulse.
//   - Handshake: tvalid holds and tdata is stable until tvalid&&tready. Then tvalid<=0 next edge,
//     unless a new byte is delivered that same cycle.
//   - Latency: N0 = first edge registering rx_bit==0 into sync flop 1.
//     tvalid is high after edge N0+2+HALF+9*UART_CYCLES.
//   - framing_error and overrun are never high for more than 1 cycle. They are mutually
//     exclusive per frame.
// STRUCTURE
//   - uart_pkg: state enum (IDLE, START, DATA, STOP), IDLE_BIT=1, START_BIT=0, STOP_BIT=1.
//     These are shared with the transmitter.
//   - Sub-module sync_2ff (parameterised reset value) for rx_bit.
//   - FSM, bit counter, shift register and output register stay in this module.
// TESTING  (bench: CLOCK_FREQ_HZ=100, BAUD_RATE=10 -> UART_CYCLES=10, HALF=5)
//   - Byte 8'hA5 (LSB first), tready=1 -> tvalid at edge N0+97, tdata=8'hA5, one beat, no flags.
//   - rx_bit low 3 cycles then high -> START aborts to IDLE; no tvalid, no flags.
//   - Frame 8'h3C with stop bit driven low -> framing_error 1-cycle pulse at edge N0+97; tvalid stays 0.
//   - tready=0, send 8'h11 then 8'h22 -> tdata stays 8'h11, overrun pulses on 2nd frame.
//     Then tready=1 -> single beat of 8'h11.
//   - Back-to-back 8'h00, 8'hFF, 8'h55 (no idle gap), tready=1 -> three beats in order, no flags.
//   - Assert m_axis_areset for 1 cycle mid-DATA of 8'h81 -> no tvalid for that frame.
//     The next clean 8'h42 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the 8N1 UART transmitter and receiver.
//   uart_state_t   frame-level state (IDLE, START, DATA, STOP)
//   IDLE_BIT       line level while no frame is in flight
//   START_BIT      line level of the start bit
//   STOP_BIT       line level of a valid stop bit
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   RESET_VALUE  level both flops take on reset
//   clk          destination clock
//   reset        synchronous reset, active-high
//   d            asynchronous input
//   q            synchronized output (two clk edges of latency)
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1 UART receiver with an AXI-Stream master holding register.
//   CLOCK_FREQ_HZ   system clock frequency (must be > 0)
//   BAUD_RATE       line rate (must be > 0, CLOCK_FREQ_HZ/BAUD_RATE >= 4)
//   m_axis_aclk     sole clock
//   m_axis_areset   synchronous reset, active-high
//   rx_bit          asynchronous UART line, idle high
//   m_axis_tvalid   received byte available
//   m_axis_tdata    received byte, bit 0 = first data bit on the line
//   m_axis_tready   downstream accepts the byte
//   framing_error   one-cycle pulse: stop bit sampled low, byte discarded
//   overrun         one-cycle pulse: byte completed while the holding register was full
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 0,
    parameter int unsigned BAUD_RATE     = 0
) (
    input  logic       m_axis_aclk,
    input  logic       m_axis_areset,
    input  logic       rx_bit,
    output logic       m_axis_tvalid,
    output logic [7:0] m_axis_tdata,
    input  logic       m_axis_tready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned UART_CYCLES = (BAUD_RATE == 0) ? 0 : CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF        = UART_CYCLES / 2;
    // Guard keeps the width legal while the parameters are still unset.
    localparam int unsigned CNT_W       = (UART_CYCLES > 1) ? $clog2(UART_CYCLES) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(UART_CYCLES - 1);

    logic              rx_s;
    uart_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [7:0]        shift_reg;

    sync_2ff #(
        .RESET_VALUE(IDLE_BIT)
    ) u_sync (
        .clk   (m_axis_aclk),
        .reset (m_axis_areset),
        .d     (rx_bit),
        .q     (rx_s)
    );

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift_reg     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // Accepted beat retires; a delivery below in the same cycle overrides this.
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_s == START_BIT) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_s == START_BIT) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        idx       <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s == STOP_BIT) begin
                            if (!m_axis_tvalid || m_axis_tready) begin
                                m_axis_tdata  <= shift_reg;
                                m_axis_tvalid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
